// File: rtl/uart_frame_assembler_pkg.sv
// Framing constants and state encoding shared by the UART receive assembler
// and the matching transmit-side framer.
package uart_frame_assembler_pkg;

  typedef enum logic [1:0] {
    StCollect = 2'd0,
    StEscape  = 2'd1,
    StDiscard = 2'd2
  } state_e;

  localparam logic [7:0] DefMarker = 8'hFF;
  localparam logic [7:0] DefEsc    = 8'hFE;
  localparam logic [7:0] EscXor    = 8'h20;

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts idle cycles while a partial frame is held and
// flags the cycle in which the count would reach TIMEOUT_CYC.
module byte_timeout_timer
  import uart_frame_assembler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  if (TIMEOUT_CYC == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, clear, run};
    assign expire        = 1'b0;
  end else begin : g_on
    localparam int unsigned TW = cnt_width(TIMEOUT_CYC);

    logic [TW-1:0] timer_q;

    always_ff @(posedge clk) begin
      if (reset || clear || !run) begin
        timer_q <= '0;
      end else if (timer_q != TW'(TIMEOUT_CYC)) begin
        timer_q <= timer_q + TW'(1);
      end
    end

    // A byte in the expiry cycle takes priority over the timeout.
    assign expire = run && !clear && (timer_q == TW'(TIMEOUT_CYC - 1));
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles NBYTES received bytes into one word closed by a MARKER byte, with
// length checking, optional byte-stuffing and an inter-byte timeout.
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int unsigned NBYTES      = 4,
  parameter logic [7:0]  MARKER      = DefMarker,
  parameter bit          ESC_EN      = 1'b1,
  parameter logic [7:0]  ESC         = DefEsc,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 0,
  localparam int unsigned DW         = 8 * NBYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic [DW-1:0] data_out,
  output logic          out_valid,
  output logic          err_len,
  output logic          err_esc,
  output logic          err_timeout,
  output logic          busy
);

  localparam int unsigned   CW   = cnt_width(NBYTES);
  localparam logic [CW-1:0] Full = CW'(NBYTES);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] shift_q, shift_d, data_d;
  logic          out_valid_d, err_len_d, err_esc_d, err_timeout_d, busy_d;
  logic          is_marker, is_esc, do_store, expire;
  logic [7:0]    store_byte;

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (in_valid),
    .run   (busy),
    .expire(expire)
  );

  assign is_marker = (in_data == MARKER);
  assign is_esc    = ESC_EN && (in_data == ESC);

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    shift_d       = shift_q;
    data_d        = data_out;
    out_valid_d   = 1'b0;
    err_len_d     = 1'b0;
    err_esc_d     = 1'b0;
    err_timeout_d = 1'b0;
    do_store      = 1'b0;
    store_byte    = in_data;

    if (in_valid) begin
      unique case (state_q)
        StCollect: begin
          if (is_marker) begin
            if (count_q == Full) begin
              data_d      = shift_q;
              out_valid_d = 1'b1;
            end else if (count_q != '0) begin
              err_len_d = 1'b1;
            end
            count_d = '0;
          end else if (is_esc) begin
            state_d = StEscape;
          end else begin
            do_store = 1'b1;
          end
        end
        StEscape: begin
          state_d = StCollect;
          if (is_marker) begin
            err_esc_d = 1'b1;
            count_d   = '0;
          end else begin
            do_store   = 1'b1;
            store_byte = in_data ^ EscXor;
          end
        end
        StDiscard: begin
          if (is_marker) begin
            state_d = StCollect;
            count_d = '0;
          end
        end
        default: begin
          state_d = StCollect;
          count_d = '0;
        end
      endcase

      // Shared store path for plain and unescaped bytes; overflow drops the frame.
      if (do_store) begin
        if (count_q == Full) begin
          err_len_d = 1'b1;
          state_d   = StDiscard;
        end else begin
          count_d = count_q + CW'(1);
          if (MSB_FIRST) begin
            shift_d = (shift_q << 8) | DW'(store_byte);
          end else begin
            for (int unsigned k = 0; k < NBYTES; k++) begin
              if (count_q == CW'(k)) shift_d[8*k +: 8] = store_byte;
            end
          end
        end
      end
    end else if (expire) begin
      err_timeout_d = 1'b1;
      count_d       = '0;
      state_d       = StCollect;
    end

    busy_d = (count_d != '0) || (state_d != StCollect);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StCollect;
      count_q     <= '0;
      shift_q     <= '0;
      data_out    <= '0;
      out_valid   <= 1'b0;
      err_len     <= 1'b0;
      err_esc     <= 1'b0;
      err_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      data_out    <= data_d;
      out_valid   <= out_valid_d;
      err_len     <= err_len_d;
      err_esc     <= err_esc_d;
      err_timeout <= err_timeout_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: default, timeout-enabled and
// LSB-first instances share one byte stream.
module tb_uart_frame_assembler;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;

  always #5 clk = ~clk;

  logic [31:0] def_data, to_data, lsb_data;
  logic def_ov, def_el, def_ee, def_et, def_busy;
  logic to_ov, to_el, to_ee, to_et, to_busy;
  logic lsb_ov, lsb_el, lsb_ee, lsb_et, lsb_busy;

  uart_frame_assembler u_def (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .data_out(def_data), .out_valid(def_ov), .err_len(def_el), .err_esc(def_ee),
    .err_timeout(def_et), .busy(def_busy)
  );

  uart_frame_assembler #(.TIMEOUT_CYC(20)) u_to (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .data_out(to_data), .out_valid(to_ov), .err_len(to_el), .err_esc(to_ee),
    .err_timeout(to_et), .busy(to_busy)
  );

  uart_frame_assembler #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .data_out(lsb_data), .out_valid(lsb_ov), .err_len(lsb_el), .err_esc(lsb_ee),
    .err_timeout(lsb_et), .busy(lsb_busy)
  );

  // Response encoding {out_valid, err_len, err_esc, err_timeout}
  localparam logic [3:0] RspNone = 4'b0000;
  localparam logic [3:0] RspOv   = 4'b1000;
  localparam logic [3:0] RspEl   = 4'b0100;
  localparam logic [3:0] RspEe   = 4'b0010;

  int tests = 0;
  int fails = 0;
  int multi = 0;
  int to_et_cnt = 0;
  int def_pulse_cnt = 0;
  logic [3:0] rsp_def, rsp_to, rsp_lsb;

  always @(negedge clk) begin
    if ($countones({def_ov, def_el, def_ee, def_et}) > 1 ||
        $countones({to_ov, to_el, to_ee, to_et}) > 1 ||
        $countones({lsb_ov, lsb_el, lsb_ee, lsb_et}) > 1) multi <= multi + 1;
    if (to_et === 1'b1) to_et_cnt <= to_et_cnt + 1;
    if ((def_ov | def_el | def_ee | def_et) === 1'b1) def_pulse_cnt <= def_pulse_cnt + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One byte strobe, responses captured one cycle later, then gap idle cycles.
  task automatic send(input logic [7:0] b, input int gap);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    rsp_def  = {def_ov, def_el, def_ee, def_et};
    rsp_to   = {to_ov, to_el, to_ee, to_et};
    rsp_lsb  = {lsb_ov, lsb_el, lsb_ee, lsb_et};
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (def_data !== 32'h0) begin
      fails++; $display("FAIL reset_data: got %h expected %h", def_data, 32'h0);
    end
    tests++;
    if ({def_ov, def_el, def_ee, def_et, def_busy} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected %b",
                        {def_ov, def_el, def_ee, def_et, def_busy}, 5'b0);
    end
    tests++;
    if (lsb_data !== 32'h0) begin
      fails++; $display("FAIL reset_lsb_data: got %h expected %h", lsb_data, 32'h0);
    end
  endtask

  task automatic test_basic();
    do_reset();
    send(8'h12, 2); send(8'h34, 2); send(8'h56, 2); send(8'h78, 2);
    tests++;
    if ({rsp_def, def_busy} !== {RspNone, 1'b1}) begin
      fails++; $display("FAIL basic_partial: got %b expected %b", {rsp_def, def_busy},
                        {RspNone, 1'b1});
    end
    send(8'hFF, 2);
    tests++;
    if (rsp_def !== RspOv) begin
      fails++; $display("FAIL basic_ov: got %b expected %b", rsp_def, RspOv);
    end
    tests++;
    if (def_data !== 32'h12345678) begin
      fails++; $display("FAIL basic_data: got %h expected %h", def_data, 32'h12345678);
    end
    tests++;
    if (rsp_lsb !== RspOv || lsb_data !== 32'h78563412) begin
      fails++; $display("FAIL lsb_first: got %b/%h expected %b/%h", rsp_lsb, lsb_data,
                        RspOv, 32'h78563412);
    end
    tests++;
    if ({def_ov, def_busy} !== 2'b00) begin
      fails++; $display("FAIL basic_pulse_end: got %b expected %b", {def_ov, def_busy}, 2'b00);
    end
  endtask

  task automatic test_escape();
    do_reset();
    send(8'h12, 0); send(8'hFE, 0); send(8'hDF, 0); send(8'h34, 0);
    send(8'hFE, 0); send(8'hDE, 0); send(8'h56, 0);
    tests++;
    if (rsp_def !== RspEl) begin
      fails++; $display("FAIL esc_overflow: got %b expected %b", rsp_def, RspEl);
    end
    send(8'hFF, 0);
    tests++;
    if ({rsp_def, def_busy, def_data} !== {RspNone, 1'b0, 32'h0}) begin
      fails++; $display("FAIL esc_discard_end: got %b/%b/%h expected %b/%b/%h",
                        rsp_def, def_busy, def_data, RspNone, 1'b0, 32'h0);
    end
    send(8'h12, 0); send(8'hFE, 0); send(8'hDF, 0); send(8'h34, 0);
    send(8'h56, 0); send(8'hFF, 0);
    tests++;
    if (rsp_def !== RspOv || def_data !== 32'h12FF3456) begin
      fails++; $display("FAIL esc_word: got %b/%h expected %b/%h", rsp_def, def_data,
                        RspOv, 32'h12FF3456);
    end
  endtask

  task automatic test_length();
    logic [3:0] r [1:6];
    send(8'hAA, 0); send(8'hBB, 0); send(8'hFF, 0);
    tests++;
    if (rsp_def !== RspEl || def_data !== 32'h12FF3456) begin
      fails++; $display("FAIL len_short: got %b/%h expected %b/%h", rsp_def, def_data,
                        RspEl, 32'h12FF3456);
    end
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), 0);
      r[i] = rsp_def;
    end
    tests++;
    if ({r[4], r[5], r[6]} !== {RspNone, RspEl, RspNone}) begin
      fails++; $display("FAIL len_long: got %b expected %b", {r[4], r[5], r[6]},
                        {RspNone, RspEl, RspNone});
    end
    tests++;
    if (def_busy !== 1'b1) begin
      fails++; $display("FAIL len_discard_busy: got %b expected %b", def_busy, 1'b1);
    end
    send(8'hFF, 0);
    tests++;
    if ({rsp_def, def_busy, def_data} !== {RspNone, 1'b0, 32'h12FF3456}) begin
      fails++; $display("FAIL len_discard_end: got %b/%b/%h expected %b/%b/%h",
                        rsp_def, def_busy, def_data, RspNone, 1'b0, 32'h12FF3456);
    end
    send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0); send(8'h0D, 0); send(8'hFF, 0);
    tests++;
    if (rsp_def !== RspOv || def_data !== 32'h0A0B0C0D) begin
      fails++; $display("FAIL len_recover: got %b/%h expected %b/%h", rsp_def, def_data,
                        RspOv, 32'h0A0B0C0D);
    end
  endtask

  task automatic test_timeout();
    int first;
    int hits;
    int et_before;
    logic busy19;
    logic busy20;
    first = -1;
    hits  = 0;
    busy19 = 1'b0;
    busy20 = 1'b1;
    do_reset();
    send(8'h11, 0); send(8'h22, 0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (to_et === 1'b1) begin
        hits++;
        if (first < 0) first = k;
      end
      if (k == 19) busy19 = to_busy;
      if (k == 20) busy20 = to_busy;
    end
    tests++;
    if (first != 20 || hits != 1) begin
      fails++; $display("FAIL timeout_cycle: got first=%0d hits=%0d expected 20/1", first, hits);
    end
    tests++;
    if ({busy19, busy20} !== 2'b10) begin
      fails++; $display("FAIL timeout_busy: got %b expected %b", {busy19, busy20}, 2'b10);
    end
    tests++;
    if ({def_busy, def_et} !== 2'b10) begin
      fails++; $display("FAIL timeout_disabled: got %b expected %b", {def_busy, def_et}, 2'b10);
    end
    send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 0); send(8'hFF, 0);
    tests++;
    if (rsp_to !== RspOv || to_data !== 32'h33445566) begin
      fails++; $display("FAIL timeout_recover: got %b/%h expected %b/%h", rsp_to, to_data,
                        RspOv, 32'h33445566);
    end
    #1 et_before = to_et_cnt;
    send(8'h11, 0); send(8'h22, 18);
    send(8'h33, 0);
    tests++;
    if (rsp_to !== RspNone) begin
      fails++; $display("FAIL timeout_byte_wins: got %b expected %b", rsp_to, RspNone);
    end
    send(8'h44, 0); send(8'hFF, 0);
    tests++;
    if (rsp_to !== RspOv || to_data !== 32'h11223344) begin
      fails++; $display("FAIL timeout_byte_word: got %b/%h expected %b/%h", rsp_to, to_data,
                        RspOv, 32'h11223344);
    end
    #1;
    tests++;
    if (to_et_cnt != et_before) begin
      fails++; $display("FAIL timeout_no_pulse: got %0d expected %0d", to_et_cnt, et_before);
    end
  endtask

  task automatic test_esc_err();
    logic [3:0] r1;
    do_reset();
    send(8'hFE, 0);
    tests++;
    if ({rsp_def, def_busy} !== {RspNone, 1'b1}) begin
      fails++; $display("FAIL esc_pending: got %b expected %b", {rsp_def, def_busy},
                        {RspNone, 1'b1});
    end
    send(8'hFF, 0);
    tests++;
    if ({rsp_def, def_busy} !== {RspEe, 1'b0}) begin
      fails++; $display("FAIL esc_marker: got %b expected %b", {rsp_def, def_busy},
                        {RspEe, 1'b0});
    end
    send(8'hFF, 0);
    r1 = rsp_def;
    send(8'hFF, 0);
    tests++;
    if ({r1, rsp_def, def_data} !== {RspNone, RspNone, 32'h0}) begin
      fails++; $display("FAIL idle_markers: got %b/%b/%h expected %b/%b/%h", r1, rsp_def,
                        def_data, RspNone, RspNone, 32'h0);
    end
  endtask

  task automatic test_reset_mid();
    int cnt_before;
    do_reset();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0);
    #1 cnt_before = def_pulse_cnt;
    do_reset();
    #1;
    tests++;
    if (def_busy !== 1'b0 || def_pulse_cnt != cnt_before) begin
      fails++; $display("FAIL reset_mid: got busy=%b pulses=%0d expected 0/%0d", def_busy,
                        def_pulse_cnt, cnt_before);
    end
    send(8'h44, 0); send(8'h55, 0); send(8'h66, 0); send(8'h77, 0); send(8'hFF, 0);
    tests++;
    if (rsp_def !== RspOv || def_data !== 32'h44556677) begin
      fails++; $display("FAIL reset_mid_word: got %b/%h expected %b/%h", rsp_def, def_data,
                        RspOv, 32'h44556677);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq_a [0:4];
    logic [7:0] seq_b [0:5];
    seq_a = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hFF};
    seq_b = '{8'h01, 8'hFE, 8'hDF, 8'h02, 8'h03, 8'hFF};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = seq_a[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (def_ov !== 1'b1 || def_data !== 32'hA1B2C3D4) begin
      fails++; $display("FAIL b2b_word: got %b/%h expected 1/%h", def_ov, def_data, 32'hA1B2C3D4);
    end
    tests++;
    if (lsb_data !== 32'hD4C3B2A1) begin
      fails++; $display("FAIL b2b_lsb: got %h expected %h", lsb_data, 32'hD4C3B2A1);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = seq_b[i];
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (def_ov !== 1'b1 || def_data !== 32'h01FF0203) begin
      fails++; $display("FAIL b2b_esc: got %b/%h expected 1/%h", def_ov, def_data, 32'h01FF0203);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_escape();
    test_length();
    test_timeout();
    test_esc_err();
    test_reset_mid();
    test_back_to_back();
    #1;
    tests++;
    if (multi != 0) begin
      fails++; $display("FAIL pulse_exclusive: got %0d cycles expected 0", multi);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
